// File: rtl/am_lock_lane_rx.sv
// Per-lane 40GBASE-R alignment marker lock: finds a lane AM, confirms it one AM period
// later, then tracks it at every expected slot and reports the logical lane number.
module am_lock_lane_rx #(
    parameter int BLOCK_W  = 66,
    parameter int AM_GAP_N = 16383,
    parameter int LOST_N   = 4,
    parameter int CNT_W    = $clog2(AM_GAP_N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               block_lock_i,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               data_v_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               am_v_o,
    output logic               am_lock_o,
    output logic               am_lock_lost_o,
    output logic [1:0]         lane_id_o
);

    localparam int MISS_W = $clog2(LOST_N + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_FIRST,
        ST_LOCKED
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [MISS_W-1:0]  r_miss;
    logic [1:0]         r_lane_id;
    logic [BLOCK_W-1:0] r_data;
    logic               r_data_v;
    logic               r_am_v;
    logic               r_am_lock;
    logic               r_lost;

    logic [3:0]         w_match;
    logic [1:0]         w_found_k;
    logic               w_any;
    logic               w_slot;
    logic               w_hit;

    // One bit per lane pattern; data_i[25:2] is {M2,M1,M0}, data_i[57:34] is {M6,M5,M4}.
    function automatic logic [3:0] am_match(input logic [BLOCK_W-1:0] blk);
        logic        ok;
        logic [23:0] m;
        m  = blk[25:2];
        ok = (blk[1:0] == 2'b10) && (blk[57:34] == ~blk[25:2]);
        am_match[0] = ok && (m == 24'h477690);
        am_match[1] = ok && (m == 24'hE6C4F0);
        am_match[2] = ok && (m == 24'h9B65C5);
        am_match[3] = ok && (m == 24'h3D79A2);
    endfunction

    // Patterns are mutually exclusive, so a plain OR encoder is enough.
    assign w_match   = am_match(data_i);
    assign w_found_k = {w_match[3] | w_match[2], w_match[3] | w_match[1]};
    assign w_any     = |w_match;
    assign w_slot    = (r_cnt == CNT_W'(AM_GAP_N));
    assign w_hit     = w_match[r_lane_id];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_UNLOCKED;
            r_cnt     <= '0;
            r_miss    <= '0;
            r_lane_id <= 2'd0;
            r_data    <= '0;
            r_data_v  <= 1'b0;
            r_am_v    <= 1'b0;
            r_am_lock <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_data   <= data_i;
            r_data_v <= valid_i;
            r_am_v   <= 1'b0;
            r_lost   <= 1'b0;
            if (!block_lock_i) begin
                // Losing sync-header lock overrides everything, including a good AM slot.
                r_state   <= ST_UNLOCKED;
                r_cnt     <= '0;
                r_miss    <= '0;
                r_am_lock <= 1'b0;
                r_lost    <= (r_state == ST_LOCKED);
            end else if (valid_i) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        r_cnt <= '0;
                        if (w_any) begin
                            r_lane_id <= w_found_k;
                            r_state   <= ST_FIRST;
                        end
                    end
                    ST_FIRST: begin
                        if (w_slot) begin
                            r_cnt <= '0;
                            if (w_hit) begin
                                r_state   <= ST_LOCKED;
                                r_am_lock <= 1'b1;
                                r_am_v    <= 1'b1;
                                r_miss    <= '0;
                            end else begin
                                r_state <= ST_UNLOCKED;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (w_slot) begin
                            r_cnt <= '0;
                            if (w_hit) begin
                                r_miss <= '0;
                                r_am_v <= 1'b1;
                            end else if (r_miss == MISS_W'(LOST_N - 1)) begin
                                r_state   <= ST_UNLOCKED;
                                r_am_lock <= 1'b0;
                                r_lost    <= 1'b1;
                                r_miss    <= '0;
                            end else begin
                                r_miss <= r_miss + MISS_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign data_o         = r_data;
    assign data_v_o       = r_data_v;
    assign am_v_o         = r_am_v;
    assign am_lock_o      = r_am_lock;
    assign am_lock_lost_o = r_lost;
    assign lane_id_o      = r_lane_id;

endmodule
